// File: rtl/rbm_gibbs_scheduler.sv
// rtl/rbm_gibbs_scheduler.sv - k-step contrastive-divergence Gibbs sequencer for one hidden and one visible layer engine
//
// Purpose: runs v0->h0->v1->h1...->vk->hk by alternately resetting and enabling the
// hidden and visible layer engines, feeding each layer's sample into the other, and
// latching the positive-phase (h0) and negative-phase (vk, hk) vectors.
//
// Ports:
//   clock, reset                  rising-edge clock, synchronous active-high reset
//   start, cd_k, visible_in       run request, step count and v0 (taken in IDLE only)
//   busy, done, error             status; done/error are one-cycle pulses
//   h0_out, vk_out, hk_out        captured result vectors
//   hid_layer_reset, vis_layer_reset, layer_rand_reset   layer controls
//   hid_data_valid, hid_input, hid_output, hid_finish    hidden layer handshake
//   vis_data_valid, vis_input, vis_output, vis_finish    visible layer handshake
module rbm_gibbs_scheduler #(
  parameter int visible_dim    = 15,
  parameter int hidden_dim     = 5,
  parameter int step_bits      = 4,
  parameter int timeout_cycles = 64
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [step_bits-1:0]   cd_k,
  input  logic [visible_dim-1:0] visible_in,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [hidden_dim-1:0]  h0_out,
  output logic [visible_dim-1:0] vk_out,
  output logic [hidden_dim-1:0]  hk_out,
  output logic                   hid_layer_reset,
  output logic                   vis_layer_reset,
  output logic                   layer_rand_reset,
  output logic                   hid_data_valid,
  output logic [visible_dim-1:0] hid_input,
  input  logic [hidden_dim-1:0]  hid_output,
  input  logic                   hid_finish,
  output logic                   vis_data_valid,
  output logic [hidden_dim-1:0]  vis_input,
  input  logic [visible_dim-1:0] vis_output,
  input  logic                   vis_finish
);

  localparam int timer_bits = $clog2(timeout_cycles + 1);
  // Timer is 0 on the first RUN cycle, so this value marks the last allowed RUN cycle.
  localparam logic [timer_bits-1:0] timer_last = timer_bits'(timeout_cycles - 1);

  typedef enum logic [2:0] {IDLE, H_CLR, H_RUN, V_CLR, V_RUN, FIN, ERR} state_t;

  state_t                 state;
  logic [visible_dim-1:0] v_reg;
  logic [hidden_dim-1:0]  h_reg;
  logic [step_bits-1:0]   k_reg;
  logic [step_bits-1:0]   step_cnt;
  logic [timer_bits-1:0]  timer;

  // Both are straight register outputs, so they hold still for a whole RUN state.
  assign hid_input = v_reg;
  assign vis_input = h_reg;

  // Every control output is registered on entry to the state it belongs to, so the
  // value seen during a state is the one assigned on the transition into it.
  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= IDLE;
      busy             <= 1'b0;
      done             <= 1'b0;
      error            <= 1'b0;
      hid_data_valid   <= 1'b0;
      vis_data_valid   <= 1'b0;
      layer_rand_reset <= 1'b0;
      hid_layer_reset  <= 1'b1;
      vis_layer_reset  <= 1'b1;
      h0_out           <= '0;
      vk_out           <= '0;
      hk_out           <= '0;
      v_reg            <= '0;
      h_reg            <= '0;
      k_reg            <= '0;
      step_cnt         <= '0;
      timer            <= '0;
    end else begin
      done             <= 1'b0;
      error            <= 1'b0;
      layer_rand_reset <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            v_reg            <= visible_in;
            vk_out           <= visible_in;  // makes cd_k=0 report vk=v0
            k_reg            <= cd_k;
            step_cnt         <= '0;
            layer_rand_reset <= 1'b1;
            busy             <= 1'b1;
            hid_layer_reset  <= 1'b1;
            hid_data_valid   <= 1'b0;
            timer            <= '0;
            state            <= H_CLR;
          end
        end
        H_CLR: begin
          hid_layer_reset <= 1'b0;
          hid_data_valid  <= 1'b1;
          timer           <= '0;
          state           <= H_RUN;
        end
        H_RUN: begin
          // A finish in the timeout cycle still counts as success.
          if (hid_finish) begin
            h_reg          <= hid_output;
            hk_out         <= hid_output;
            if (step_cnt == '0) h0_out <= hid_output;
            hid_data_valid <= 1'b0;
            if (step_cnt == k_reg) begin
              done            <= 1'b1;
              hid_layer_reset <= 1'b1;
              vis_layer_reset <= 1'b1;
              state           <= FIN;
            end else begin
              vis_layer_reset <= 1'b1;
              timer           <= '0;
              state           <= V_CLR;
            end
          end else if (timer == timer_last) begin
            done            <= 1'b1;
            error           <= 1'b1;
            hid_data_valid  <= 1'b0;
            hid_layer_reset <= 1'b1;
            vis_layer_reset <= 1'b1;
            state           <= ERR;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        V_CLR: begin
          vis_layer_reset <= 1'b0;
          vis_data_valid  <= 1'b1;
          timer           <= '0;
          state           <= V_RUN;
        end
        V_RUN: begin
          if (vis_finish) begin
            v_reg           <= vis_output;
            vk_out          <= vis_output;
            step_cnt        <= step_cnt + 1'b1;
            vis_data_valid  <= 1'b0;
            hid_layer_reset <= 1'b1;
            timer           <= '0;
            state           <= H_CLR;
          end else if (timer == timer_last) begin
            done            <= 1'b1;
            error           <= 1'b1;
            vis_data_valid  <= 1'b0;
            hid_layer_reset <= 1'b1;
            vis_layer_reset <= 1'b1;
            state           <= ERR;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        FIN, ERR: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy            <= 1'b0;
          hid_data_valid  <= 1'b0;
          vis_data_valid  <= 1'b0;
          hid_layer_reset <= 1'b1;
          vis_layer_reset <= 1'b1;
          state           <= IDLE;
        end
      endcase
    end
  end

endmodule
